mdu_ctrl: RTL and testbench

Execute-stage sequencer for the RV32M extension. Accepts M-type requests from decode over a valid/ready handshake and drives the team's combinational multiplier through dedicated operand/op ports. It also performs DIV/DIVU/REM/REMU in an internal 32-iteration restoring divider. It returns one registered result per request to writeback over a second valid/ready handshake.

---
 rtl/mdu_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: RV32M execute-stage sequencer driving an external combinational multiplier.
// Define MDU_DIV_EN to build the 32-step restoring divider; otherwise divide ops return 0.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// MUL   | multiplier operands presented, result captured at the end of the cycle
// DIV   | one restoring divide step per cycle, 32 steps
// FIX   | sign correction and quotient/remainder select
// DONE  | result held on out_* until writeback accepts it
module mdu_ctrl #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_funct3,
    input  logic [data_width-1:0] in_rs1,
    input  logic [data_width-1:0] in_rs2,
    input  logic [4:0]            in_rd,
    input  logic                  flush,
    output logic [data_width-1:0] mul_a,
    output logic [data_width-1:0] mul_b,
    output logic [1:0]            mul_op,
    input  logic [data_width-1:0] mul_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_result,
    output logic [4:0]            out_rd,
    output logic                  busy
);

    localparam int msb = data_width - 1;
    localparam logic [data_width-1:0] min_neg = {1'b1, {(data_width-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [2:0]            funct3_q;
    logic [1:0]            mul_op_in;
    logic                  accept;
    logic [data_width-1:0] mul_fix;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready && !flush;

    // MULHSU runs on the unsigned-high multiplier and corrects for a negative rs1
    assign mul_fix = (funct3_q == 3'b010 && mul_a[msb]) ? mul_result - mul_b : mul_result;

`ifdef MDU_DIV_EN
    logic                  in_signed, div_zero, div_ovf, op_signed;
    logic [4:0]            count;
    logic [data_width-1:0] special_res, dividend_abs, divisor_abs;
    logic [data_width-1:0] rem_q, quo_q, quo_fix, rem_fix;
    logic [data_width:0]   rem_sh, diff;

    assign in_signed    = ~in_funct3[0];
    assign div_zero     = (in_rs2 == '0);
    assign div_ovf      = in_signed && (in_rs1 == min_neg) && (in_rs2 == '1);
    assign special_res  = div_zero ? (in_funct3[1] ? in_rs1 : '1)
                                   : (in_funct3[1] ? '0 : min_neg);
    assign dividend_abs = (in_signed && in_rs1[msb]) ? -in_rs1 : in_rs1;

    assign op_signed   = ~funct3_q[0];
    assign divisor_abs = (op_signed && mul_b[msb]) ? -mul_b : mul_b;
    assign rem_sh      = {rem_q, quo_q[msb]};
    assign diff        = rem_sh - {1'b0, divisor_abs};
    assign quo_fix     = (op_signed && (mul_a[msb] ^ mul_b[msb])) ? -quo_q : quo_q;
    assign rem_fix     = (op_signed && mul_a[msb]) ? -rem_q : rem_q;
`endif

    always_comb begin
        mul_op_in = 2'b00;
        case (in_funct3)
            3'b001:         mul_op_in = 2'b01;
            3'b010, 3'b011: mul_op_in = 2'b11;
            default:        mul_op_in = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef MDU_DIV_EN
                    if (!in_funct3[2])          state_nxt = S_MUL;
                    else if (div_zero || div_ovf) state_nxt = S_DONE;
                    else                        state_nxt = S_DIV;
`else
                    state_nxt = S_MUL;
`endif
                end
            end
            S_MUL: state_nxt = S_DONE;
`ifdef MDU_DIV_EN
            S_DIV: if (count == 5'd31) state_nxt = S_FIX;
            S_FIX: state_nxt = S_DONE;
`endif
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q   <= 3'b000;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_op     <= 2'b00;
            out_rd     <= 5'd0;
            out_result <= '0;
`ifdef MDU_DIV_EN
            count      <= 5'd0;
            rem_q      <= '0;
            quo_q      <= '0;
`endif
        end else begin
            if (accept) begin
                funct3_q <= in_funct3;
                mul_a    <= in_rs1;
                mul_b    <= in_rs2;
                mul_op   <= mul_op_in;
                out_rd   <= in_rd;
`ifdef MDU_DIV_EN
                count    <= 5'd0;
                rem_q    <= '0;
                quo_q    <= dividend_abs;
                if (in_funct3[2] && (div_zero || div_ovf)) out_result <= special_res;
`endif
            end
            case (state)
                S_MUL: out_result <= funct3_q[2] ? '0 : mul_fix;
`ifdef MDU_DIV_EN
                S_DIV: begin
                    count <= count + 5'd1;
                    if (!diff[data_width]) begin
                        rem_q <= diff[data_width-1:0];
                        quo_q <= {quo_q[msb-1:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[data_width-1:0];
                        quo_q <= {quo_q[msb-1:0], 1'b0};
                    end
                end
                S_FIX: out_result <= funct3_q[1] ? rem_fix : quo_fix;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed plan vectors, randomized requests against an
// arithmetic reference model, back-pressure, flush and asynchronous reset scenarios.
module tb_mdu_ctrl;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_rs1 = '0, in_rs2 = '0;
    logic [4:0]  in_rd = 5'd0;
    logic        flush = 1'b0;
    logic [31:0] mul_a, mul_b, mul_result;
    logic [1:0]  mul_op;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.data_width(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .flush(flush), .mul_a(mul_a), .mul_b(mul_b), .mul_op(mul_op),
        .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );

    // External combinational multiplier
    logic [63:0] p_uu, p_ss;
    always_comb begin
        p_uu = {32'b0, mul_a} * {32'b0, mul_b};
        p_ss = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
        case (mul_op)
            2'b01:   mul_result = p_ss[63:32];
            2'b11:   mul_result = p_uu[63:32];
            default: mul_result = p_uu[31:0];
        endcase
    end

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (f3[2] && !DIV_EN) return 32'd0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!DIV_EN || !f3[2] || b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issues one request, reports when out_valid first rises; starts/ends 1 ns after a rising edge.
    task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input bit handoff,
                           output logic [31:0] res, output logic [4:0] rd_o, output int lat,
                           output logic [1:0] op_seen, output int busy_cnt);
        in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_funct3 = 3'($urandom); in_rs1 = $urandom; in_rs2 = $urandom; in_rd = 5'($urandom);
        op_seen = mul_op;
        busy_cnt = busy ? 1 : 0;
        lat = -1;
        res = 'x;
        rd_o = 'x;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end else begin
            res = out_result;
            rd_o = out_rd;
            if (handoff) begin
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_result !== 32'd0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
        checks++; if (out_rd !== 5'd0) begin failures++; $display("FAIL reset_out_rd got=%h exp=0", out_rd); end
        checks++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin failures++; $display("FAIL reset_mul_ab got=%h/%h exp=0", mul_a, mul_b); end
        checks++; if (mul_op !== 2'b00) begin failures++; $display("FAIL reset_mul_op got=%b exp=00", mul_op); end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, exp;
        logic [1:0]  op;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[10];
        logic [31:0] res, e;
        logic [4:0]  rd_o;
        logic [1:0]  op_seen;
        int          lat, bc, el;
        vecs[0] = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 2'b00};
        vecs[1] = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 2'b11};
        vecs[2] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2'b11};
        vecs[3] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2'b01};
        vecs[4] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 2'b00};
        vecs[5] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 2'b00};
        vecs[6] = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2'b00};
        vecs[7] = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2'b00};
        vecs[8] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2'b00};
        vecs[9] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00};
        for (int i = 0; i < 10; i++) begin
            e  = (vecs[i].f3[2] && !DIV_EN) ? 32'd0 : vecs[i].exp;
            el = ref_lat(vecs[i].f3, vecs[i].a, vecs[i].b);
            run_req(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 3), 1'b1, res, rd_o, lat, op_seen, bc);
            checks++; if (res !== e) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, e); end
            checks++; if (rd_o !== 5'(i + 3)) begin failures++; $display("FAIL dir%0d_rd got=%0d exp=%0d", i, rd_o, i + 3); end
            checks++; if (lat != el) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el); end
            checks++; if (bc != el + 1) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, el + 1); end
            if (!vecs[i].f3[2] || !DIV_EN) begin
                checks++; if (op_seen !== vecs[i].op) begin failures++; $display("FAIL dir%0d_mul_op got=%b exp=%b", i, op_seen, vecs[i].op); end
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, e;
        logic [4:0]  rd, rd_o;
        logic [1:0]  op_seen;
        int          lat, bc, el;
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 17));
                3: b = -32'($urandom_range(1, 17));
                default: ;
            endcase
            rd = 5'($urandom);
            e  = ref_res(f3, a, b);
            el = ref_lat(f3, a, b);
            run_req(f3, a, b, rd, 1'b1, res, rd_o, lat, op_seen, bc);
            checks++; if (res !== e || rd_o !== rd || lat != el) begin
                failures++;
                $display("FAIL rand%0d f3=%b a=%h b=%h got=%h/rd%0d/lat%0d exp=%h/rd%0d/lat%0d",
                         i, f3, a, b, res, rd_o, lat, e, rd, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, e, e2;
        logic [4:0]  rd_o;
        logic [1:0]  op_seen;
        int          lat, bc, lat2;
        e = ref_res(3'b000, 32'd1234, 32'd5678);
        run_req(3'b000, 32'd1234, 32'd5678, 5'd17, 1'b0, res, rd_o, lat, op_seen, bc);
        checks++; if (res !== e) begin failures++; $display("FAIL bp_first_result got=%h exp=%h", res, e); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_result !== e || out_rd !== 5'd17 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got=v%b/%h/rd%0d/rdy%b exp=v1/%h/rd17/rdy0", i, out_valid, out_result, out_rd, in_ready, e);
            end
        end
        e2 = ref_res(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
        out_ready = 1'b1;
        in_valid = 1'b1; in_funct3 = 3'b011; in_rs1 = 32'hDEAD_BEEF; in_rs2 = 32'h1234_5678; in_rd = 5'd9;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL bp_handoff got=v%b/busy%b exp=v0/busy0", out_valid, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_next_accept got=busy%b exp=busy1", busy); end
        lat2 = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat2 = i; break; end
        end
        checks++; if (lat2 != 1 || out_result !== e2 || out_rd !== 5'd9) begin
            failures++; $display("FAIL bp_next_result got=%h/rd%0d/lat%0d exp=%h/rd9/lat1", out_result, out_rd, lat2, e2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [4:0]  rd_o;
        logic [1:0]  op_seen;
        int          lat, bc, ov;
        ov = 0;
        in_valid = 1'b1; in_funct3 = 3'b100; in_rs1 = 32'd1000; in_rs2 = 32'd7; in_rd = 5'd4; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef MDU_DIV_EN
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov++;
        end
`endif
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_idle got=busy%b/rdy%b exp=busy0/rdy1", busy, in_ready);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov++;
        end
        out_ready = 1'b0;
        checks++; if (ov != 0) begin failures++; $display("FAIL flush_no_valid got=%0d pulses exp=0", ov); end

        in_valid = 1'b1; flush = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd3; in_rs2 = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_blocks_accept got=busy%b exp=0", busy); end

        run_req(3'b000, 32'd3, 32'd5, 5'd11, 1'b0, res, rd_o, lat, op_seen, bc);
        checks++; if (res !== 32'd15 || rd_o !== 5'd11 || lat != 1) begin
            failures++; $display("FAIL flush_next_mul got=%h/rd%0d/lat%0d exp=0000000f/rd11/lat1", res, rd_o, lat);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_in_done got=v%b/rdy%b exp=v0/rdy1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic [4:0]  rd_o;
        logic [1:0]  op_seen;
        int          lat, bc, ov;
        ov = 0;
        in_valid = 1'b1; in_funct3 = 3'b100; in_rs1 = 32'd100; in_rs2 = 32'd7; in_rd = 5'd21;
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef MDU_DIV_EN
        repeat (5) @(posedge clk);
        #1;
`endif
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov++;
        end
        out_ready = 1'b0;
        checks++; if (ov != 0) begin failures++; $display("FAIL rst_no_valid got=%0d pulses exp=0", ov); end
        run_req(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 5'd2, 1'b1, res, rd_o, lat, op_seen, bc);
        checks++; if (res !== 32'hFFFF_FFFF || lat != 1) begin
            failures++; $display("FAIL rst_next_mulh got=%h/lat%0d exp=ffffffff/lat1", res, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
